// File: rtl/dma_copy32_if.sv
// Bus bundle shared by the DMA register port and the DMA initiator port.
// It carries req/gnt/rvalid handshakes with byte enables. The master modport
// drives a request. The slave modport answers it.
interface dma_copy32_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dma_copy32.sv
// dma_copy32 - word-copy DMA engine.
// The CPU programs SRC/DST/LEN through the register port and then writes start.
// The engine then copies LEN 32-bit words over the initiator port. Each word is
// one read followed by one write, and the port never has more than one
// transaction outstanding.
// Optional feature macro: DMA_IRQ_EN.
//   Defined:   adds the interrupt enable bit (CTRL/STATUS[3]). irq = ie & (done | aborted).
//   Undefined: irq is tied low, CTRL[3] writes are ignored and STATUS[3] reads 0.
module dma_copy32 #(
    parameter logic [19:0] BASE_ADDR = 20'h00022,
    parameter int unsigned LEN_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    dma_copy32_if.slave  s_bus,
    dma_copy32_if.master m_bus,
    output logic         irq
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // SRC/DST are word addresses. The two low bits are implicitly zero.
    logic [29:0]        r_src;
    logic [29:0]        r_dst;
    logic [LEN_W-1:0]   r_len;
    logic [31:0]        r_data;
    logic               r_done;
    logic               r_aborted;
    logic               r_abort_pend;
    logic               r_s_gnt;
    logic               r_s_rvalid;
    logic [31:0]        r_s_rdata;
    logic [3:0]         r_m_be;

    logic               w_ie;
    logic               w_decode;
    logic               w_s_acc;
    logic               w_s_wr;
    logic [11:0]        w_off;
    logic               w_idle;
    logic               w_busy;
    logic               w_wr_src;
    logic               w_wr_dst;
    logic               w_wr_len;
    logic               w_ctrl_wr;
    logic               w_start_cmd;
    logic               w_abort_cmd;
    logic               w_start_go;
    logic               w_abort;
    logic [31:0]        w_be_mask;
    logic [29:0]        w_src_merge;
    logic [29:0]        w_dst_merge;
    logic [LEN_W-1:0]   w_len_merge;
    logic [31:0]        w_status;
    logic [31:0]        w_rd_mux;
    logic               w_len_last;

    logic               w_m_req;
    logic               w_m_we;
    logic [31:0]        w_m_addr;
    logic [31:0]        w_m_wdata;
    logic               w_ld_data;
    logic               w_advance;
    logic               w_to_done;
    logic               w_to_abort;

    // ---------------- register port decode ----------------
    assign w_decode = (s_bus.addr[31:12] == BASE_ADDR);
    // Accept a request once. The grant pulse itself blocks a second accept.
    assign w_s_acc  = s_bus.req & w_decode & ~r_s_gnt;
    assign w_s_wr   = w_s_acc & s_bus.we;
    assign w_off    = s_bus.addr[11:0];

    assign w_idle   = (r_state == ST_IDLE);
    assign w_busy   = ~w_idle;

    // SRC/DST/LEN are frozen while a copy is running.
    assign w_wr_src    = w_s_wr & (w_off == 12'h000) & w_idle;
    assign w_wr_dst    = w_s_wr & (w_off == 12'h004) & w_idle;
    assign w_wr_len    = w_s_wr & (w_off == 12'h008) & w_idle;
    assign w_ctrl_wr   = w_s_wr & (w_off == 12'h00C) & s_bus.be[0];
    assign w_start_cmd = w_ctrl_wr & s_bus.wdata[0];
    assign w_abort_cmd = w_ctrl_wr & s_bus.wdata[1];

    // Start is only honoured when idle. If start and abort arrive together, start wins when idle.
    assign w_start_go  = w_start_cmd & w_idle;
    // Abort is remembered until the FSM reaches a point where it can stop cleanly.
    assign w_abort     = r_abort_pend | (w_abort_cmd & w_busy);

    // Per-byte write mask built from the byte enables
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_mask
            assign w_be_mask[gi*8 +: 8] = {8{s_bus.be[gi]}};
        end
    endgenerate

    assign w_src_merge = (r_src & ~w_be_mask[31:2]) | (s_bus.wdata[31:2] & w_be_mask[31:2]);
    assign w_dst_merge = (r_dst & ~w_be_mask[31:2]) | (s_bus.wdata[31:2] & w_be_mask[31:2]);
    assign w_len_merge = (r_len & ~w_be_mask[LEN_W-1:0]) |
                         (s_bus.wdata[LEN_W-1:0] & w_be_mask[LEN_W-1:0]);

    assign w_status   = {28'd0, w_ie, r_aborted, r_done, w_busy};
    assign w_len_last = (r_len == LEN_W'(1));

    // Register read mux. Unmapped offsets read as zero.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            12'h000: w_rd_mux = {r_src, 2'b00};
            12'h004: w_rd_mux = {r_dst, 2'b00};
            12'h008: w_rd_mux = 32'(r_len);
            12'h00C: w_rd_mux = w_status;
            default: w_rd_mux = 32'd0;
        endcase
    end

`ifdef DMA_IRQ_EN
    logic r_ie;

    // Interrupt enable, written through CTRL[3] at any time
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ie <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ie <= s_bus.wdata[3];
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_ie & (r_done | r_aborted);
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    // ---------------- copy FSM ----------------
    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus initiator outputs and datapath strobes.
    // After a grant the FSM always waits for its response, so at most one transaction is in flight.
    always_comb begin
        w_state_next = r_state;
        w_m_req      = 1'b0;
        w_m_we       = 1'b0;
        w_m_addr     = 32'd0;
        w_m_wdata    = 32'd0;
        w_ld_data    = 1'b0;
        w_advance    = 1'b0;
        w_to_done    = 1'b0;
        w_to_abort   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) begin
                    if (r_len == '0) begin
                        w_to_done = 1'b1;
                    end else begin
                        w_state_next = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                w_m_req  = 1'b1;
                w_m_addr = {r_src, 2'b00};
                if (m_bus.gnt) begin
                    w_state_next = ST_RD_WAIT;
                end else if (w_abort) begin
                    w_state_next = ST_IDLE;
                    w_to_abort   = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (m_bus.rvalid) begin
                    if (w_abort) begin
                        w_state_next = ST_IDLE;
                        w_to_abort   = 1'b1;
                    end else begin
                        w_ld_data    = 1'b1;
                        w_state_next = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                w_m_req   = 1'b1;
                w_m_we    = 1'b1;
                w_m_addr  = {r_dst, 2'b00};
                w_m_wdata = r_data;
                if (m_bus.gnt) begin
                    w_state_next = ST_WR_WAIT;
                end else if (w_abort) begin
                    w_state_next = ST_IDLE;
                    w_to_abort   = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (m_bus.rvalid) begin
                    // The write has landed, so count it as progress even if an abort is pending.
                    w_advance = 1'b1;
                    if (w_abort) begin
                        w_state_next = ST_IDLE;
                        w_to_abort   = 1'b1;
                    end else if (w_len_last) begin
                        w_state_next = ST_IDLE;
                        w_to_done    = 1'b1;
                    end else begin
                        w_state_next = ST_RD_REQ;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Register port handshake. Read data is captured on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s_gnt    <= 1'b0;
            r_s_rvalid <= 1'b0;
            r_s_rdata  <= 32'd0;
        end else begin
            r_s_gnt    <= w_s_acc;
            r_s_rvalid <= r_s_gnt;
            if (w_s_acc) begin
                r_s_rdata <= w_rd_mux;
            end
        end
    end

    // Programming registers, copy progress and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_src        <= 30'd0;
            r_dst        <= 30'd0;
            r_len        <= '0;
            r_data       <= 32'd0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_m_be       <= 4'h0;
        end else begin
            r_m_be <= 4'hF;
            if (w_wr_src) r_src <= w_src_merge;
            if (w_wr_dst) r_dst <= w_dst_merge;
            if (w_wr_len) r_len <= w_len_merge;
            if (w_ld_data) r_data <= m_bus.rdata;
            // Address wrap past 0xFFFFFFFC is the natural 30-bit rollover.
            if (w_advance) begin
                r_src <= r_src + 30'd1;
                r_dst <= r_dst + 30'd1;
                r_len <= r_len - LEN_W'(1);
            end
            if (w_start_go) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end
            if (w_to_done) begin
                r_done <= 1'b1;
            end
            if (w_to_abort) begin
                r_aborted <= 1'b1;
                r_done    <= 1'b0;
            end
            r_abort_pend <= (w_state_next == ST_IDLE) ? 1'b0 : w_abort;
        end
    end

    assign s_bus.gnt    = r_s_gnt;
    assign s_bus.rvalid = r_s_rvalid;
    assign s_bus.rdata  = r_s_rdata;

    assign m_bus.req    = w_m_req;
    assign m_bus.we     = w_m_we;
    assign m_bus.be     = r_m_be;
    assign m_bus.addr   = w_m_addr;
    assign m_bus.wdata  = w_m_wdata;

endmodule
